// File: rtl/if_pkg.sv
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_pkg;

   localparam int unsigned IF_PC_W     = 32;
   localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;

   // Redirect source, listed from highest to lowest priority
   typedef enum logic [2:0] {
      RDIR_NONE  = 3'd0,
      RDIR_START = 3'd1,
      RDIR_ECALL = 3'd2,
      RDIR_JMP   = 3'd3,
      RDIR_PIPE  = 3'd4
   } rdir_e;

   typedef struct packed {
      logic [31:0]        inst;
      logic [IF_PC_W-1:2] pc;
   } q_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_prefetch_queue.sv
// ============================================================================
// Module      : if_prefetch_queue
// Description : Synchronous FIFO with push, pop, flush and occupancy level.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_prefetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 62
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [DW-1:0]              i_push_data,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [DW-1:0]              o_head,
   output logic                       o_valid,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [DW-1:0] r_mem [0:DEPTH-1];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign w_push = i_push & (r_level != C_FULL);
   assign w_pop  = i_pop & (r_level != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push & ~i_flush) begin
         r_mem[r_wptr] <= i_push_data;
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_valid = (r_level != '0);
   assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/inst_1r1w.sv
// ============================================================================
// Module      : inst_1r1w
// Description : Instruction RAM, one synchronous read port, one write port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_1r1w #(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic [AW-1:0] i_radr,
   output logic [DW-1:0] o_rdata,
   input  logic [AW-1:0] i_wadr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_wen
);

   logic [DW-1:0] r_mem [0:(2**AW)-1];

   // Read and write in the same process: a colliding read sees the old word
   always_ff @(posedge clk) begin
      o_rdata <= r_mem[i_radr];
      if (i_wen) begin
         r_mem[i_wadr] <= i_wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_prefetch_stage.sv
// ============================================================================
// Module      : if_prefetch_stage
// Description : RV32I fetch stage with prefetch queue, IRAM and monitor port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int unsigned      PC_W     = 32,
   parameter int unsigned      IRAM_AW  = 12,
   parameter int unsigned      QDEPTH   = 4,
   parameter logic [PC_W-1:0]  RESET_PC = '0,
   parameter logic [31:0]      NOP_INST = IF_NOP_INST
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic [31:0]               inst_id,
   output logic [PC_W-3:0]           pc_id,
   output logic                      valid_id,
   input  logic                      ready_id,
   input  logic                      jmp_condition_ex,
   input  logic [PC_W-3:0]           jmp_adr_ex,
   input  logic                      ecall_condition_ex,
   input  logic [PC_W-3:0]           csr_mtvec_ex,
   input  logic                      rst_pipe,
   input  logic                      cpu_start,
   input  logic [PC_W-3:0]           start_adr,
   input  logic [IRAM_AW-1:0]        i_ram_radr,
   output logic [31:0]               i_ram_rdata,
   input  logic                      i_read_sel,
   input  logic [IRAM_AW-1:0]        i_ram_wadr,
   input  logic [31:0]               i_ram_wdata,
   input  logic                      i_ram_wen,
   output logic [$clog2(QDEPTH):0]   q_level,
   output logic [PC_W-1:0]           pc_data
);

   localparam int unsigned PCI_W = PC_W - 2;
   localparam int unsigned LW    = $clog2(QDEPTH) + 1;

   logic [PCI_W-1:0]   r_pc_if;
   logic [PCI_W-1:0]   r_pend_pc;
   logic               r_rd_pend;
   logic [PCI_W-1:0]   r_pc_last;

   rdir_e              w_rdir;
   logic               w_redirect;
   logic [PCI_W-1:0]   w_pc_next;
   logic               w_pop;
   logic               w_issue;
   logic [LW:0]        w_credit;
   logic               w_push;
   logic [IRAM_AW-1:0] w_ram_radr;
   logic [31:0]        w_ram_rdata;
   q_entry_t           w_push_entry;
   q_entry_t           w_head;
   logic               w_q_valid;
   logic [LW-1:0]      w_q_level;
   logic [PCI_W-1:0]   w_head_pc;

   always_comb begin
      w_rdir = RDIR_NONE;
      if (cpu_start) begin
         w_rdir = RDIR_START;
      end else if (ecall_condition_ex) begin
         w_rdir = RDIR_ECALL;
      end else if (jmp_condition_ex) begin
         w_rdir = RDIR_JMP;
      end else if (rst_pipe) begin
         w_rdir = RDIR_PIPE;
      end
   end

   assign w_redirect = (w_rdir != RDIR_NONE);

   // Slots already promised (queued + in flight) after this cycle's pop
   assign w_pop    = w_q_valid & ready_id;
   assign w_credit = {1'b0, w_q_level} + {{LW{1'b0}}, r_rd_pend} - {{LW{1'b0}}, w_pop};
   assign w_issue  = ~i_read_sel & ~w_redirect & (w_credit < (LW+1)'(QDEPTH));
   assign w_push   = r_rd_pend & ~w_redirect;

   always_comb begin
      w_pc_next = r_pc_if;
      case (w_rdir)
         RDIR_START: w_pc_next = start_adr;
         RDIR_ECALL: w_pc_next = csr_mtvec_ex;
         RDIR_JMP:   w_pc_next = jmp_adr_ex;
         RDIR_PIPE:  w_pc_next = r_pc_if;
         default: begin
            if (w_issue) begin
               w_pc_next = r_pc_if + PCI_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc_if   <= RESET_PC[PC_W-1:2];
         r_rd_pend <= 1'b0;
         r_pend_pc <= '0;
         r_pc_last <= '0;
      end else begin
         r_pc_if   <= w_pc_next;
         r_rd_pend <= w_issue;
         if (w_issue) begin
            r_pend_pc <= r_pc_if;
         end
         if (w_q_valid) begin
            r_pc_last <= w_head_pc;
         end
      end
   end

   assign w_ram_radr = i_read_sel ? i_ram_radr : r_pc_if[IRAM_AW-1:0];

   inst_1r1w #(
      .AW (IRAM_AW),
      .DW (32)
   ) u_iram (
      .clk     (clk),
      .i_radr  (w_ram_radr),
      .o_rdata (w_ram_rdata),
      .i_wadr  (i_ram_wadr),
      .i_wdata (i_ram_wdata),
      .i_wen   (i_ram_wen)
   );

   assign w_push_entry.inst = w_ram_rdata;
   assign w_push_entry.pc   = (IF_PC_W-2)'(r_pend_pc);

   if_prefetch_queue #(
      .DEPTH (QDEPTH),
      .DW    ($bits(q_entry_t))
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .i_flush     (w_redirect),
      .o_head      (w_head),
      .o_valid     (w_q_valid),
      .o_level     (w_q_level)
   );

   assign w_head_pc   = PCI_W'(w_head.pc);
   assign valid_id    = w_q_valid;
   assign inst_id     = w_q_valid ? w_head.inst : NOP_INST;
   assign pc_id       = w_q_valid ? w_head_pc : r_pc_last;
   assign q_level     = w_q_level;
   assign i_ram_rdata = w_ram_rdata;
   assign pc_data     = {r_pc_if, 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
// ============================================================================
// Module      : tb_if_prefetch_stage
// Description : Directed self-checking bench for if_prefetch_stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_prefetch_stage;

   localparam logic [31:0] C_NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst_id;
   logic [29:0] pc_id;
   logic        valid_id;
   logic        ready_id = 1'b0;
   logic        jmp_condition_ex = 1'b0;
   logic [29:0] jmp_adr_ex = '0;
   logic        ecall_condition_ex = 1'b0;
   logic [29:0] csr_mtvec_ex = '0;
   logic        rst_pipe = 1'b0;
   logic        cpu_start = 1'b0;
   logic [29:0] start_adr = '0;
   logic [11:0] i_ram_radr = '0;
   logic [31:0] i_ram_rdata;
   logic        i_read_sel = 1'b0;
   logic [11:0] i_ram_wadr = '0;
   logic [31:0] i_ram_wdata = '0;
   logic        i_ram_wen = 1'b0;
   logic [2:0]  q_level;
   logic [31:0] pc_data;

   int n_tests = 0;
   int n_fail  = 0;

   if_prefetch_stage #(
      .PC_W     (32),
      .IRAM_AW  (12),
      .QDEPTH   (4),
      .RESET_PC (32'h0),
      .NOP_INST (C_NOP)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .inst_id            (inst_id),
      .pc_id              (pc_id),
      .valid_id           (valid_id),
      .ready_id           (ready_id),
      .jmp_condition_ex   (jmp_condition_ex),
      .jmp_adr_ex         (jmp_adr_ex),
      .ecall_condition_ex (ecall_condition_ex),
      .csr_mtvec_ex       (csr_mtvec_ex),
      .rst_pipe           (rst_pipe),
      .cpu_start          (cpu_start),
      .start_adr          (start_adr),
      .i_ram_radr         (i_ram_radr),
      .i_ram_rdata        (i_ram_rdata),
      .i_read_sel         (i_read_sel),
      .i_ram_wadr         (i_ram_wadr),
      .i_ram_wdata        (i_ram_wdata),
      .i_ram_wen          (i_ram_wen),
      .q_level            (q_level),
      .pc_data            (pc_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // RAM image: word a holds A500_0000 | a
   function automatic logic [31:0] word(input int a);
      return 32'hA500_0000 | 32'(a);
   endfunction

   task automatic expect_head(input string tag, input int pc);
      check({tag, ".valid"}, {31'd0, valid_id}, 32'd1);
      check({tag, ".pc"}, {2'b00, pc_id}, 32'(pc));
      check({tag, ".inst"}, inst_id, word(pc));
   endtask

   initial begin
      // Preload while held in reset
      for (int a = 0; a < 160; a++) begin
         @(posedge clk);
         #1;
         i_ram_wen   = 1'b1;
         i_ram_wadr  = 12'(a);
         i_ram_wdata = word(a);
      end
      tick();
      i_ram_wen = 1'b0;
      check("rst.valid", {31'd0, valid_id}, 32'd0);
      check("rst.inst", inst_id, C_NOP);
      check("rst.pc_id", {2'b00, pc_id}, 32'd0);
      check("rst.level", {29'd0, q_level}, 32'd0);
      check("rst.pc_data", pc_data, 32'd0);

      // 1: start at 0x10, stream
      rst = 1'b0;
      cpu_start = 1'b1;
      start_adr = 30'h10;
      ready_id  = 1'b1;
      tick();
      cpu_start = 1'b0;
      check("t1.valid0", {31'd0, valid_id}, 32'd0);
      check("t1.pc_data", pc_data, 32'h40);
      tick();
      check("t1.valid1", {31'd0, valid_id}, 32'd0);
      tick();
      expect_head("t1.h10", 'h10);
      tick();
      expect_head("t1.h11", 'h11);
      tick();
      expect_head("t1.h12", 'h12);
      tick();
      expect_head("t1.h13", 'h13);

      // 2: stall, queue saturates, then drain without loss
      ready_id = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("t2.level", {29'd0, q_level}, 32'd4);
      check("t2.pc_data", pc_data, 32'h17 << 2);
      expect_head("t2.h13", 'h13);
      ready_id = 1'b1;
      for (int p = 'h14; p <= 'h18; p++) begin
         tick();
         expect_head("t2.drain", p);
      end

      // 3: full queue, jump
      ready_id = 1'b0;
      tick();
      tick();
      tick();
      check("t3.full", {29'd0, q_level}, 32'd4);
      check("t3.pc_data", pc_data, 32'h1C << 2);
      jmp_condition_ex = 1'b1;
      jmp_adr_ex = 30'h40;
      tick();
      jmp_condition_ex = 1'b0;
      ready_id = 1'b1;
      check("t3.valid", {31'd0, valid_id}, 32'd0);
      check("t3.level", {29'd0, q_level}, 32'd0);
      check("t3.inst_nop", inst_id, C_NOP);
      check("t3.pc_hold", {2'b00, pc_id}, 32'h18);
      tick();
      check("t3.gap", {31'd0, valid_id}, 32'd0);
      tick();
      expect_head("t3.h40", 'h40);
      tick();
      expect_head("t3.h41", 'h41);

      // 4: ecall beats jmp (read in flight is dropped), cpu_start beats both
      ecall_condition_ex = 1'b1;
      csr_mtvec_ex = 30'h80;
      jmp_condition_ex = 1'b1;
      jmp_adr_ex = 30'h40;
      tick();
      ecall_condition_ex = 1'b0;
      jmp_condition_ex = 1'b0;
      check("t4.valid", {31'd0, valid_id}, 32'd0);
      check("t4.pc_data", pc_data, 32'h80 << 2);
      tick();
      check("t4.stale", {31'd0, valid_id}, 32'd0);
      tick();
      expect_head("t4.h80", 'h80);
      cpu_start = 1'b1;
      start_adr = 30'h20;
      ecall_condition_ex = 1'b1;
      jmp_condition_ex = 1'b1;
      tick();
      cpu_start = 1'b0;
      ecall_condition_ex = 1'b0;
      jmp_condition_ex = 1'b0;
      check("t4.start_pc", pc_data, 32'h20 << 2);
      check("t4.start_valid", {31'd0, valid_id}, 32'd0);
      tick();
      tick();
      expect_head("t4.h20", 'h20);

      // 5: monitor steals the read port for 3 cycles
      i_read_sel = 1'b1;
      i_ram_radr = 12'h005;
      tick();
      check("t5.rd5", i_ram_rdata, word(5));
      expect_head("t5.h21", 'h21);
      i_ram_radr = 12'h006;
      tick();
      check("t5.rd6", i_ram_rdata, word(6));
      check("t5.empty", {31'd0, valid_id}, 32'd0);
      check("t5.nop", inst_id, C_NOP);
      check("t5.pc_hold", {2'b00, pc_id}, 32'h21);
      i_ram_radr  = 12'h007;
      i_ram_wen   = 1'b1;
      i_ram_wadr  = 12'h007;
      i_ram_wdata = 32'hDEAD_BEEF;
      tick();
      check("t5.rbw_old", i_ram_rdata, word(7));
      i_ram_wen  = 1'b0;
      i_read_sel = 1'b0;
      tick();
      check("t5.resume_gap", {31'd0, valid_id}, 32'd0);
      tick();
      expect_head("t5.h22", 'h22);
      tick();
      expect_head("t5.h23", 'h23);
      i_read_sel = 1'b1;
      i_ram_radr = 12'h007;
      tick();
      check("t5.rbw_new", i_ram_rdata, 32'hDEAD_BEEF);
      expect_head("t5.h24", 'h24);
      i_read_sel = 1'b0;

      // 6: asynchronous reset mid-stream
      #3;
      rst = 1'b1;
      #1;
      check("t6.valid", {31'd0, valid_id}, 32'd0);
      check("t6.inst", inst_id, C_NOP);
      check("t6.pc_id", {2'b00, pc_id}, 32'd0);
      check("t6.level", {29'd0, q_level}, 32'd0);
      check("t6.pc_data", pc_data, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("t6.gap", {31'd0, valid_id}, 32'd0);
      check("t6.pc_inc", pc_data, 32'd4);
      tick();
      expect_head("t6.h00", 0);
      tick();
      expect_head("t6.h01", 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
